// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - fetch stage bus bundle: IM port, BR register read, PC write, redirect and ID handshake
interface if_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RSEL_W = 3
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [RSEL_W-1:0] br_addr;
  logic [ADDR_W-1:0] br_value;
  logic              pc_wr;
  logic [ADDR_W-1:0] pc_wr_val;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;

  // fetch stage side
  modport master (
    output imem_req, imem_addr, br_addr, pc_wr, pc_wr_val, id_valid, id_instr, id_pc,
    input  imem_rdata, br_value, redirect, redirect_pc, id_ready
  );

  // memory / register file / ID side
  modport slave (
    input  imem_req, imem_addr, br_addr, pc_wr, pc_wr_val, id_valid, id_instr, id_pc,
    output imem_rdata, br_value, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch with local B/BR resolution and a DEPTH-entry prefetch queue
module if_fetch_queue #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              RSEL_W   = 3
) (
  input logic             clk,
  input logic             reset,
  if_fetch_queue_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [6:0] OP_B  = 7'b1100000;
  localparam logic [6:0] OP_BR = 7'b1100010;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] mem_pc_q [DEPTH];
  logic [ADDR_W-1:0] mem_pc_d [DEPTH];
  logic [DATA_W-1:0] mem_instr_q [DEPTH];
  logic [DATA_W-1:0] mem_instr_d [DEPTH];

  logic              resp_valid;
  logic [6:0]        opcode;
  logic              is_b, is_br, taken;
  logic [ADDR_W-1:0] imm_off, target_base, target, seq_pc;
  logic [CNT_W-1:0]  occupancy;
  logic              deq, enq, issue;

  // Decode the response, resolve B/BR, decide issue and compute next queue/fetch state
  always_comb begin
    resp_valid  = inflight_q && !kill_q;
    opcode      = bus.imem_rdata[31:25];
    is_b        = resp_valid && (opcode == OP_B);
    is_br       = resp_valid && (opcode == OP_BR);
    taken       = is_b || is_br;
    imm_off     = {{(ADDR_W-18){bus.imem_rdata[15]}}, bus.imem_rdata[15:0], 2'b00};
    target_base = is_br ? bus.br_value : req_pc_q;
    target      = (target_base + imm_off) & ~ADDR_W'(3);
    seq_pc      = fetch_pc_q + ADDR_W'(4);

    // A killed response does not occupy a queue slot, so it is not counted here
    occupancy = count_q + CNT_W'(resp_valid);
    deq       = (count_q != '0) && bus.id_ready;
    issue     = !reset && !bus.redirect && ((occupancy < CNT_W'(DEPTH)) || deq);
    enq       = resp_valid && !bus.redirect;

    bus.imem_req  = issue;
    bus.imem_addr = fetch_pc_q;
    bus.br_addr   = resp_valid ? bus.imem_rdata[22 +: RSEL_W] : '0;
    bus.pc_wr     = !reset && !bus.redirect && (issue || taken);
    bus.pc_wr_val = taken ? target : seq_pc;
    bus.id_valid  = (count_q != '0);
    bus.id_instr  = mem_instr_q[head_q];
    bus.id_pc     = mem_pc_q[head_q];

    fetch_pc_d = fetch_pc_q;
    if (issue) fetch_pc_d = seq_pc;
    if (taken) fetch_pc_d = target;
    if (bus.redirect) fetch_pc_d = bus.redirect_pc & ~ADDR_W'(3);

    // The sequential fetch issued alongside a taken branch is on the wrong path
    inflight_d = issue;
    kill_d     = issue && taken;
    req_pc_d   = issue ? fetch_pc_q : req_pc_q;

    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    if (enq) begin
      mem_pc_d[tail_q]    = req_pc_q;
      mem_instr_d[tail_q] = bus.imem_rdata;
    end

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    if (deq) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (bus.redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers; reset drops the in-flight request and empties the queue at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      kill_q      <= kill_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
  logic clk = 1'b0;
  logic reset;

  if_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .RSEL_W(3)) bus ();

  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .RSEL_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0]       start_pc;
    logic [31:0]       patch_addr;
    logic [31:0]       patch_instr;
    logic [31:0]       br_val;
    logic [3:0][31:0]  exp_pc;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  logic [31:0] patch_addr = 32'hDEAD_BEE0;
  logic [31:0] patch_instr = 32'h0;
  logic [31:0] held_pc;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == patch_addr) return patch_instr;
    return {7'h00, a[24:0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] s, pa, pi, bv, e0, e1, e2, e3);
    vec_t v;
    v.start_pc    = s;
    v.patch_addr  = pa;
    v.patch_instr = pi;
    v.br_val      = bv;
    v.exp_pc[0]   = e0;
    v.exp_pc[1]   = e1;
    v.exp_pc[2]   = e2;
    v.exp_pc[3]   = e3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic push_pc(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_at(pc);
    exp_q.push_back(e);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain: %0d entries never reached ID, required 0", name, exp_q.size());
    end
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  // Instruction memory: fixed one-cycle read latency
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= instr_at(bus.imem_addr);
  end

  // Scoreboard: every ID handshake is compared against the next expected entry
  always @(negedge clk) begin
    if (mon_en && !reset && bus.id_valid && bus.id_ready && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("id_pc", bus.id_pc, mon_e.pc);
      chk("id_instr", bus.id_instr, mon_e.instr);
    end
  end

  initial begin
    vecs[0] = mk(32'h0000_0000, 32'hDEAD_BEE0, 32'h0,         32'h0,   32'h0, 32'h4, 32'h8, 32'hC);
    vecs[1] = mk(32'h0000_0008, 32'h0000_0010, 32'hC000_FFFC, 32'h0,   32'h8, 32'hC, 32'h10, 32'h0);
    vecs[2] = mk(32'h0000_0020, 32'h0000_0020, 32'hC540_0002, 32'h200, 32'h20, 32'h208, 32'h20C, 32'h210);
    vecs[3] = mk(32'h0000_0403, 32'hDEAD_BEE0, 32'h0,         32'h0,   32'h400, 32'h404, 32'h408, 32'h40C);
    vecs[4] = mk(32'hFFFF_FFF8, 32'hDEAD_BEE0, 32'h0,         32'h0,   32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4);
    vecs[5] = mk(32'h0000_00F8, 32'h0000_0100, 32'hC000_0003, 32'h0,   32'hF8, 32'hFC, 32'h100, 32'h10C);

    reset           = 1'b1;
    bus.imem_rdata  = '0;
    bus.br_value    = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("rst imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst pc_wr", {31'b0, bus.pc_wr}, 32'h0);
    chk("rst br_addr", {29'b0, bus.br_addr}, 32'h0);
    chk("rst id_instr", bus.id_instr, 32'h0);
    chk("rst id_pc", bus.id_pc, 32'h0);

    reset = 1'b0;
    @(negedge clk);
    chk("c0 imem_req", {31'b0, bus.imem_req}, 32'h1);
    chk("c0 imem_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("c1 imem_addr", bus.imem_addr, 32'h4);
    chk("c1 id_valid", {31'b0, bus.id_valid}, 32'h0);
    @(negedge clk);
    chk("c2 id_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("c2 id_pc", bus.id_pc, 32'h0);

    for (int v = 0; v < 6; v++) begin
      @(posedge clk);
      #1;
      patch_addr   = vecs[v].patch_addr;
      patch_instr  = vecs[v].patch_instr;
      bus.br_value = vecs[v].br_val;
      do_redirect(vecs[v].start_pc);
      for (int k = 0; k < 4; k++) push_pc(vecs[v].exp_pc[k]);
      mon_en = 1'b1;
      wait_drain($sformatf("vec%0d", v));
    end

    patch_addr   = 32'h0000_0020;
    patch_instr  = 32'hC540_0002;
    bus.br_value = 32'h200;
    @(posedge clk);
    #1;
    do_redirect(32'h20);
    @(negedge clk);
    @(negedge clk);
    chk("br br_addr", {29'b0, bus.br_addr}, 32'h5);
    chk("br pc_wr", {31'b0, bus.pc_wr}, 32'h1);
    chk("br pc_wr_val", bus.pc_wr_val, 32'h208);

    @(posedge clk);
    #1;
    bus.id_ready = 1'b0;
    do_redirect(32'h40);
    repeat (5) @(negedge clk);
    held_pc = bus.id_pc;
    chk("stall head early", held_pc, 32'h40);
    repeat (5) @(negedge clk);
    chk("stall imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("stall id_valid", {31'b0, bus.id_valid}, 32'h1);
    chk("stall head late", bus.id_pc, 32'h40);
    chk("stall fetch depth", bus.imem_addr, 32'h50);
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) push_pc(32'h40 + 32'(4 * k));
    mon_en       = 1'b1;
    bus.id_ready = 1'b1;
    wait_drain("stall");

    @(posedge clk);
    #1;
    bus.id_ready = 1'b0;
    do_redirect(32'h60);
    repeat (4) @(posedge clk);
    #1;
    chk("flush pre id_valid", {31'b0, bus.id_valid}, 32'h1);
    do_redirect(32'h403);
    chk("flush id_valid", {31'b0, bus.id_valid}, 32'h0);
    for (int k = 0; k < 4; k++) push_pc(32'h400 + 32'(4 * k));
    mon_en       = 1'b1;
    bus.id_ready = 1'b1;
    wait_drain("flush");

    @(posedge clk);
    #1;
    do_redirect(32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap addr0", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap addr1", bus.imem_addr, 32'h0);
    @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst imem_req", {31'b0, bus.imem_req}, 32'h0);
    chk("midrst pc_wr", {31'b0, bus.pc_wr}, 32'h0);
    chk("midrst id_valid", {31'b0, bus.id_valid}, 32'h0);
    chk("midrst id_pc", bus.id_pc, 32'h0);
    chk("midrst id_instr", bus.id_instr, 32'h0);
    chk("midrst br_addr", {29'b0, bus.br_addr}, 32'h0);
    chk("midrst imem_addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) push_pc(32'(4 * k));
    mon_en = 1'b1;
    wait_drain("post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
